// File: rtl/rom_burst_reader_pkg.sv
// Shared types for the ROM burst reader: FSM state encoding and index-width helper.
package rom_reader_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  // One extra bit so a counter can reach NUM_WORDS itself, e.g. 64 words on a 6-bit ROM.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Request/ROM/result bundle between the burst reader and its consumer.
interface rom_burst_reader_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int NUM_WORDS = 32
);
  import rom_reader_pkg::*;
  localparam int IW = idx_w(NUM_WORDS);

  logic                        start;
  logic [ADDR_W-1:0]           base_addr;
  logic [DATA_W-1:0]           rom_q;
  logic [ADDR_W-1:0]           address;
  logic                        busy;
  logic                        done;
  logic [NUM_WORDS*DATA_W-1:0] rom_data;
  logic                        word_valid;
  logic [IW-1:0]               word_index;
  logic [DATA_W-1:0]           word_data;

  modport master (output start, base_addr, rom_q,
                  input  address, busy, done, rom_data, word_valid, word_index, word_data);
  modport slave  (input  start, base_addr, rom_q,
                  output address, busy, done, rom_data, word_valid, word_index, word_data);
endinterface

// File: rtl/rom_burst_reader_latency_pipe.sv
// Tag delay line matching the ROM read latency; its output marks which word rom_q carries.
module rom_latency_pipe #(
  parameter int LATENCY = 2,
  parameter int IW      = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_i,
  input  logic [IW-1:0] idx_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);
  logic [LATENCY-1:0]         vld_pipe_q;
  logic [LATENCY-1:0][IW-1:0] idx_pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= vld_i;
      idx_pipe_q[0] <= idx_i;
      for (int k = 1; k < LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        idx_pipe_q[k] <= idx_pipe_q[k-1];
      end
    end
  end

  assign vld_o = vld_pipe_q[LATENCY-1];
  assign idx_o = idx_pipe_q[LATENCY-1];
endmodule

// File: rtl/rom_burst_reader.sv
// Burst reader: issues NUM_WORDS consecutive ROM addresses, captures each word into a flat buffer
// and a per-word stream tap, one word per cycle.
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int NUM_WORDS   = 32,
  parameter int ROM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  rom_burst_reader_if.slave bus
);
  localparam int            IW       = idx_w(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  state_e                      state_q;
  logic [ADDR_W-1:0]           base_q, address_q;
  logic [IW-1:0]               issue_cnt_q, iss_idx_q, word_index_q;
  logic                        iss_vld_q, busy_q, done_q, word_valid_q;
  logic [DATA_W-1:0]           word_data_q;
  logic [NUM_WORDS*DATA_W-1:0] rom_data_q;
  logic                        cap_vld;
  logic [IW-1:0]               cap_idx;

  rom_latency_pipe #(.LATENCY(ROM_LATENCY), .IW(IW)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .vld_i (iss_vld_q),
    .idx_i (iss_idx_q),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      address_q    <= '0;
      issue_cnt_q  <= '0;
      iss_idx_q    <= '0;
      iss_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_valid_q <= 1'b0;
      word_index_q <= '0;
      word_data_q  <= '0;
      rom_data_q   <= '0;
    end else begin
      iss_vld_q    <= 1'b0;
      word_valid_q <= 1'b0;
      // The tag leaving the pipe says rom_q holds word cap_idx this cycle.
      if (cap_vld) begin
        word_valid_q <= 1'b1;
        word_index_q <= cap_idx;
        word_data_q  <= bus.rom_q;
        for (int w = 0; w < NUM_WORDS; w++)
          if (cap_idx == IW'(w)) rom_data_q[w*DATA_W +: DATA_W] <= bus.rom_q;
      end
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            base_q      <= bus.base_addr;
            issue_cnt_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          address_q   <= base_q + ADDR_W'(issue_cnt_q);
          iss_vld_q   <= 1'b1;
          iss_idx_q   <= issue_cnt_q;
          issue_cnt_q <= issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_IDX) state_q <= DRAIN;
        end
        DRAIN: begin
          if (cap_vld && cap_idx == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address    = address_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_index = word_index_q;
  assign bus.word_data  = word_data_q;
endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: four builds (default, latency 1, latency 4, 64-word full range)
// checked cycle by cycle against the expected burst schedule and a key-xor ROM.
module tb_rom_burst_reader;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       start_a [NI];
  logic [5:0] base_a  [NI];
  logic [7:0] rom_key;

  logic [5:0]   obs_addr [NI];
  logic         obs_busy [NI], obs_done [NI], obs_wv [NI];
  logic [6:0]   obs_wi   [NI];
  logic [7:0]   obs_wd   [NI];
  logic [511:0] obs_data [NI];
  logic [7:0]   rp [NI][4];

  int checks = 0;
  int errors = 0;

  function automatic int nw_of(input int n);
    return (n == 3) ? 64 : 32;
  endfunction

  function automatic int lat_of(input int n);
    return (n == 1) ? 1 : (n == 2) ? 4 : 2;
  endfunction

  function automatic logic [7:0] word_of(input logic [5:0] a);
    return {2'b00, a} ^ rom_key;
  endfunction

  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(32)) b0 ();
  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(32)) b1 ();
  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(32)) b2 ();
  rom_burst_reader_if #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(64)) b3 ();

  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(32), .ROM_LATENCY(2))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(32), .ROM_LATENCY(1))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(32), .ROM_LATENCY(4))
    u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  rom_burst_reader #(.DATA_W(8), .ADDR_W(6), .NUM_WORDS(64), .ROM_LATENCY(2))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  assign b0.start = start_a[0], b0.base_addr = base_a[0], b0.rom_q = rp[0][1];
  assign b1.start = start_a[1], b1.base_addr = base_a[1], b1.rom_q = rp[1][0];
  assign b2.start = start_a[2], b2.base_addr = base_a[2], b2.rom_q = rp[2][3];
  assign b3.start = start_a[3], b3.base_addr = base_a[3], b3.rom_q = rp[3][1];

  assign obs_addr[0] = b0.address, obs_busy[0] = b0.busy, obs_done[0] = b0.done,
         obs_wv[0] = b0.word_valid, obs_wi[0] = {1'b0, b0.word_index},
         obs_wd[0] = b0.word_data, obs_data[0] = {256'b0, b0.rom_data};
  assign obs_addr[1] = b1.address, obs_busy[1] = b1.busy, obs_done[1] = b1.done,
         obs_wv[1] = b1.word_valid, obs_wi[1] = {1'b0, b1.word_index},
         obs_wd[1] = b1.word_data, obs_data[1] = {256'b0, b1.rom_data};
  assign obs_addr[2] = b2.address, obs_busy[2] = b2.busy, obs_done[2] = b2.done,
         obs_wv[2] = b2.word_valid, obs_wi[2] = {1'b0, b2.word_index},
         obs_wd[2] = b2.word_data, obs_data[2] = {256'b0, b2.rom_data};
  assign obs_addr[3] = b3.address, obs_busy[3] = b3.busy, obs_done[3] = b3.done,
         obs_wv[3] = b3.word_valid, obs_wi[3] = b3.word_index,
         obs_wd[3] = b3.word_data, obs_data[3] = b3.rom_data;

  // Synchronous ROM: word for the sampled address appears rp[n][L-1], i.e. L cycles later.
  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      rp[n][0] <= word_of(obs_addr[n]);
      for (int k = 1; k < 4; k++) rp[n][k] <= rp[n][k-1];
    end
  end

  task automatic run_burst(input string tag, input int n, input logic [5:0] base, input int inj);
    int nw, lat, last, idx;
    logic [5:0] ea;
    logic exp_wv;
    nw = nw_of(n); lat = lat_of(n); last = nw + lat + 1;
    @(posedge clk); #1;
    start_a[n] = 1'b1; base_a[n] = base;
    @(posedge clk); #1;
    start_a[n] = 1'b0; base_a[n] = ~base;
    checks++;
    if (obs_busy[n] !== 1'b1 || obs_done[n] !== 1'b0) begin
      errors++;
      $display("FAIL %s accept busy/done got %b/%b want 1/0", tag, obs_busy[n], obs_done[n]);
    end
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start_a[n] = 1'b0;
      ea = base + 6'(((c <= nw) ? c : nw) - 1);
      checks++;
      if (obs_addr[n] !== ea) begin
        errors++;
        $display("FAIL %s addr cyc %0d got %0d want %0d", tag, c, obs_addr[n], ea);
      end
      checks++;
      if (obs_done[n] !== (c == last) || obs_busy[n] !== (c < last)) begin
        errors++;
        $display("FAIL %s done/busy cyc %0d got %b/%b want %b/%b", tag, c,
                 obs_done[n], obs_busy[n], (c == last), (c < last));
      end
      exp_wv = (c >= lat + 2);
      checks++;
      if (obs_wv[n] !== exp_wv) begin
        errors++;
        $display("FAIL %s word_valid cyc %0d got %b want %b", tag, c, obs_wv[n], exp_wv);
      end
      if (exp_wv) begin
        idx = c - lat - 2;
        checks++;
        if (obs_wi[n] !== 7'(idx) || obs_wd[n] !== word_of(base + 6'(idx))) begin
          errors++;
          $display("FAIL %s word cyc %0d got idx %0d data %h want idx %0d data %h", tag, c,
                   obs_wi[n], obs_wd[n], idx, word_of(base + 6'(idx)));
        end
      end
      if (c == inj) start_a[n] = 1'b1;
    end
    for (int i = 0; i < nw; i++) begin
      checks++;
      if (obs_data[n][i*8 +: 8] !== word_of(base + 6'(i))) begin
        errors++;
        $display("FAIL %s rom_data[%0d] got %h want %h", tag, i, obs_data[n][i*8 +: 8],
                 word_of(base + 6'(i)));
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (obs_done[n] !== 1'b1 || obs_busy[n] !== 1'b0 || obs_wv[n] !== 1'b0) begin
        errors++;
        $display("FAIL %s post-done got done %b busy %b wv %b want 1 0 0", tag,
                 obs_done[n], obs_busy[n], obs_wv[n]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < NI; n++) begin
      checks++;
      if ({obs_addr[n], obs_busy[n], obs_done[n], obs_wv[n], obs_wi[n], obs_wd[n]} !== 25'd0) begin
        errors++;
        $display("FAIL reset outputs inst %0d got addr %0d busy %b done %b wv %b wi %0d wd %h",
                 n, obs_addr[n], obs_busy[n], obs_done[n], obs_wv[n], obs_wi[n], obs_wd[n]);
      end
      checks++;
      if (obs_data[n] !== 512'd0) begin
        errors++;
        $display("FAIL reset rom_data inst %0d not zero", n);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_default();
    rom_key = 8'hA5;
    run_burst("default", 0, 6'd0, -1);
  endtask

  task automatic test_wrap();
    rom_key = 8'($urandom);
    run_burst("wrap", 0, 6'd40, -1);
  endtask

  task automatic test_latency();
    rom_key = 8'($urandom);
    run_burst("lat1", 1, 6'($urandom), -1);
    run_burst("lat4", 2, 6'($urandom), -1);
  endtask

  task automatic test_ignore_start();
    rom_key = 8'($urandom);
    run_burst("ignore_start", 0, 6'($urandom), 10);
  endtask

  task automatic test_reset_mid();
    rom_key = 8'($urandom);
    @(posedge clk); #1;
    start_a[0] = 1'b1; base_a[0] = 6'($urandom);
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    repeat (15) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({obs_addr[0], obs_busy[0], obs_done[0], obs_wv[0], obs_wi[0], obs_wd[0]} !== 25'd0 ||
        obs_data[0] !== 512'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got addr %0d busy %b done %b wv %b wd %h want all 0",
               obs_addr[0], obs_busy[0], obs_done[0], obs_wv[0], obs_wd[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (obs_done[0] !== 1'b0 || obs_busy[0] !== 1'b0 || obs_wv[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid after got done %b busy %b wv %b want 0 0 0",
               obs_done[0], obs_busy[0], obs_wv[0]);
    end
    run_burst("after_reset", 0, 6'($urandom), -1);
  endtask

  task automatic test_restart();
    rom_key = 8'($urandom);
    run_burst("restart", 0, 6'($urandom), -1);
  endtask

  task automatic test_full_range();
    rom_key = 8'($urandom);
    run_burst("n64_a", 3, 6'($urandom), -1);
    rom_key = 8'($urandom);
    run_burst("n64_b", 3, 6'($urandom), -1);
  endtask

  initial begin
    for (int n = 0; n < NI; n++) begin
      start_a[n] = 1'b0;
      base_a[n]  = '0;
    end
    rom_key = 8'hA5;
    test_reset();
    test_default();
    test_wrap();
    test_latency();
    test_ignore_start();
    test_reset_mid();
    test_restart();
    test_full_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
